// File: rtl/parking_zone_if.sv
// Gate-side event bus and status returned by the parking zone controller.
// master drives the sensor/capacity events, slave is the controller.
interface parking_zone_if #(
  parameter int ZONES  = 2,
  parameter int CNT_W  = 10,
  parameter int ZIDX_W = 1
);
  logic                    enable;
  logic                    car_entered;
  logic [ZIDX_W-1:0]       entry_zone;
  logic                    car_exited;
  logic [ZIDX_W-1:0]       exit_zone;
  logic                    cap_wr;
  logic [ZIDX_W-1:0]       cap_zone;
  logic [CNT_W-1:0]        cap_value;
  logic [ZONES*CNT_W-1:0]  parked_cars;
  logic [ZONES*CNT_W-1:0]  vacated_space;
  logic [ZONES-1:0]        is_vacated_space;
  logic                    entry_grant;
  logic [ZIDX_W-1:0]       granted_zone;
  logic                    entry_deny;
  logic                    no_car_error;
  logic                    capacity_error;
  logic                    zone_error;

  modport master (
    output enable, car_entered, entry_zone, car_exited, exit_zone,
           cap_wr, cap_zone, cap_value,
    input  parked_cars, vacated_space, is_vacated_space, entry_grant,
           granted_zone, entry_deny, no_car_error, capacity_error, zone_error
  );

  modport slave (
    input  enable, car_entered, entry_zone, car_exited, exit_zone,
           cap_wr, cap_zone, cap_value,
    output parked_cars, vacated_space, is_vacated_space, entry_grant,
           granted_zone, entry_deny, no_car_error, capacity_error, zone_error
  );
endinterface

// File: rtl/parking_zone_ctrl.sv
// Multi-zone parking occupancy controller: per-zone counts with run-time capacities,
// entry grant/deny with optional spill into zone 0, registered status and error pulses.
module parking_zone_ctrl #(
  parameter int ZONES       = 2,
  parameter int CNT_W       = 10,
  parameter int ZIDX_W      = 1,
  parameter int DEFAULT_CAP = 500,
  parameter bit SPILL       = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  parking_zone_if.slave bus
);
  localparam int                NSLOT = 1 << ZIDX_W;
  localparam logic [CNT_W-1:0]  DCAP  = CNT_W'(DEFAULT_CAP);
  localparam logic [ZIDX_W:0]   ZLIM  = (ZIDX_W+1)'(ZONES);

  function automatic logic in_range(input logic [ZIDX_W-1:0] idx);
    return {1'b0, idx} < ZLIM;
  endfunction

  function automatic logic has_space(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] cap);
    return cnt < cap;
  endfunction

  logic [CNT_W-1:0]       cnt_p0 [NSLOT];
  logic [CNT_W-1:0]       cap_p0 [NSLOT];
  logic                   grant_p0, deny_p0, nce_p0, cerr_p0, zerr_p0;
  logic [ZIDX_W-1:0]      gz_p0;

  logic [CNT_W-1:0]       cnt_p1 [NSLOT];
  logic [CNT_W-1:0]       cap_p1 [NSLOT];
  logic [ZONES*CNT_W-1:0] vac_p1;
  logic [ZONES-1:0]       isvac_p1;
  logic                   grant_p1, deny_p1, nce_p1, cerr_p1, zerr_p1;
  logic [ZIDX_W-1:0]      gz_p1;
  logic [ZONES*CNT_W-1:0] parked;

  // Stage p0: resolve exit, then entry against the post-exit count, then capacity write
  // against the post-event count.
  always_comb begin
    cnt_p0   = cnt_p1;
    cap_p0   = cap_p1;
    grant_p0 = 1'b0;
    deny_p0  = 1'b0;
    gz_p0    = '0;
    nce_p0   = 1'b0;
    cerr_p0  = 1'b0;
    zerr_p0  = 1'b0;

    if (bus.enable && bus.car_exited) begin
      if (!in_range(bus.exit_zone))
        zerr_p0 = 1'b1;
      else if (cnt_p0[bus.exit_zone] == '0)
        nce_p0 = 1'b1;
      else
        cnt_p0[bus.exit_zone] = cnt_p0[bus.exit_zone] - 1'b1;
    end

    if (bus.enable && bus.car_entered) begin
      if (!in_range(bus.entry_zone)) begin
        zerr_p0 = 1'b1;
      end else if (has_space(cnt_p0[bus.entry_zone], cap_p0[bus.entry_zone])) begin
        cnt_p0[bus.entry_zone] = cnt_p0[bus.entry_zone] + 1'b1;
        grant_p0 = 1'b1;
        gz_p0    = bus.entry_zone;
      end else if (SPILL && (bus.entry_zone != '0) && has_space(cnt_p0[0], cap_p0[0])) begin
        cnt_p0[0] = cnt_p0[0] + 1'b1;
        grant_p0  = 1'b1;
      end else begin
        deny_p0 = 1'b1;
      end
    end

    // Capacity writes are not gated by enable so reprogramming works while the gates are idle.
    if (bus.cap_wr) begin
      if (!in_range(bus.cap_zone))
        zerr_p0 = 1'b1;
      else if (bus.cap_value >= cnt_p0[bus.cap_zone])
        cap_p0[bus.cap_zone] = bus.cap_value;
      else
        cerr_p0 = 1'b1;
    end
  end

  // Stage p1: state and every output registered together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int z = 0; z < NSLOT; z++) begin
        cnt_p1[z] <= '0;
        cap_p1[z] <= DCAP;
      end
      for (int z = 0; z < ZONES; z++)
        vac_p1[z*CNT_W +: CNT_W] <= DCAP;
      isvac_p1 <= {ZONES{DCAP != '0}};
      grant_p1 <= 1'b0;
      deny_p1  <= 1'b0;
      gz_p1    <= '0;
      nce_p1   <= 1'b0;
      cerr_p1  <= 1'b0;
      zerr_p1  <= 1'b0;
    end else begin
      cnt_p1 <= cnt_p0;
      cap_p1 <= cap_p0;
      for (int z = 0; z < ZONES; z++) begin
        vac_p1[z*CNT_W +: CNT_W] <= cap_p0[z] - cnt_p0[z];
        isvac_p1[z]              <= cap_p0[z] != cnt_p0[z];
      end
      grant_p1 <= grant_p0;
      deny_p1  <= deny_p0;
      gz_p1    <= gz_p0;
      nce_p1   <= nce_p0;
      cerr_p1  <= cerr_p0;
      zerr_p1  <= zerr_p0;
    end
  end

  always_comb begin
    parked = '0;
    for (int z = 0; z < ZONES; z++)
      parked[z*CNT_W +: CNT_W] = cnt_p1[z];
  end

  assign bus.parked_cars      = parked;
  assign bus.vacated_space    = vac_p1;
  assign bus.is_vacated_space = isvac_p1;
  assign bus.entry_grant      = grant_p1;
  assign bus.granted_zone     = gz_p1;
  assign bus.entry_deny       = deny_p1;
  assign bus.no_car_error     = nce_p1;
  assign bus.capacity_error   = cerr_p1;
  assign bus.zone_error       = zerr_p1;
endmodule

// File: tb/tb_parking_zone_ctrl.sv
// Bench for parking_zone_ctrl: a SPILL=1 and a SPILL=0 instance driven identically,
// each tracked by an occupancy model, directed scenarios followed by random traffic.
module tb_parking_zone_ctrl;
  localparam int ZONES  = 2;
  localparam int CNT_W  = 10;
  localparam int ZIDX_W = 2;
  localparam int DCAP   = 500;

  logic clk;
  logic reset_n;
  logic enable, car_entered, car_exited, cap_wr;
  logic [ZIDX_W-1:0] entry_zone, exit_zone, cap_zone;
  logic [CNT_W-1:0]  cap_value;

  int n_total = 0;
  int n_pass  = 0;

  // model state: index 0 = spill instance, 1 = no-spill instance
  int m_cnt [2][ZONES];
  int m_cap [2][ZONES];
  bit e_grant [2], e_deny [2], e_nce [2], e_cerr [2], e_zerr [2];
  int e_gz [2];

  parking_zone_if #(.ZONES(ZONES), .CNT_W(CNT_W), .ZIDX_W(ZIDX_W)) ifs ();
  parking_zone_if #(.ZONES(ZONES), .CNT_W(CNT_W), .ZIDX_W(ZIDX_W)) ifn ();

  parking_zone_ctrl #(.ZONES(ZONES), .CNT_W(CNT_W), .ZIDX_W(ZIDX_W),
                      .DEFAULT_CAP(DCAP), .SPILL(1'b1)) u_spill (
    .clk(clk), .reset_n(reset_n), .bus(ifs));

  parking_zone_ctrl #(.ZONES(ZONES), .CNT_W(CNT_W), .ZIDX_W(ZIDX_W),
                      .DEFAULT_CAP(DCAP), .SPILL(1'b0)) u_nospill (
    .clk(clk), .reset_n(reset_n), .bus(ifn));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int park(input int k, input int z);
    logic [ZONES*CNT_W-1:0] v;
    v = (k == 0) ? ifs.parked_cars : ifn.parked_cars;
    return int'(v[z*CNT_W +: CNT_W]);
  endfunction

  function automatic int vac(input int k, input int z);
    logic [ZONES*CNT_W-1:0] v;
    v = (k == 0) ? ifs.vacated_space : ifn.vacated_space;
    return int'(v[z*CNT_W +: CNT_W]);
  endfunction

  task automatic apply();
    ifs.enable = enable;     ifn.enable = enable;
    ifs.car_entered = car_entered; ifn.car_entered = car_entered;
    ifs.entry_zone = entry_zone;   ifn.entry_zone = entry_zone;
    ifs.car_exited = car_exited;   ifn.car_exited = car_exited;
    ifs.exit_zone = exit_zone;     ifn.exit_zone = exit_zone;
    ifs.cap_wr = cap_wr;     ifn.cap_wr = cap_wr;
    ifs.cap_zone = cap_zone; ifn.cap_zone = cap_zone;
    ifs.cap_value = cap_value; ifn.cap_value = cap_value;
  endtask

  // Occupancy bookkeeping: a car leaves, then a car arrives, then the capacity may change.
  task automatic model_step(input int k, input bit sp);
    int xz, ez, cz, cv;
    xz = int'(exit_zone);
    ez = int'(entry_zone);
    cz = int'(cap_zone);
    cv = int'(cap_value);
    e_grant[k] = 0; e_deny[k] = 0; e_nce[k] = 0; e_cerr[k] = 0; e_zerr[k] = 0; e_gz[k] = 0;
    if (!reset_n) begin
      for (int z = 0; z < ZONES; z++) begin
        m_cnt[k][z] = 0;
        m_cap[k][z] = DCAP;
      end
      return;
    end
    if (enable && car_exited) begin
      if (xz >= ZONES) e_zerr[k] = 1;
      else if (m_cnt[k][xz] == 0) e_nce[k] = 1;
      else m_cnt[k][xz] -= 1;
    end
    if (enable && car_entered) begin
      if (ez >= ZONES) e_zerr[k] = 1;
      else if (m_cnt[k][ez] < m_cap[k][ez]) begin
        m_cnt[k][ez] += 1; e_grant[k] = 1; e_gz[k] = ez;
      end else if (sp && ez != 0 && m_cnt[k][0] < m_cap[k][0]) begin
        m_cnt[k][0] += 1; e_grant[k] = 1; e_gz[k] = 0;
      end else e_deny[k] = 1;
    end
    if (cap_wr) begin
      if (cz >= ZONES) e_zerr[k] = 1;
      else if (cv >= m_cnt[k][cz]) m_cap[k][cz] = cv;
      else e_cerr[k] = 1;
    end
  endtask

  task automatic compare_all();
    logic [ZONES-1:0] iv;
    logic g, d, n, c, e;
    logic [ZIDX_W-1:0] gz;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        iv = ifs.is_vacated_space; g = ifs.entry_grant; d = ifs.entry_deny;
        n = ifs.no_car_error; c = ifs.capacity_error; e = ifs.zone_error; gz = ifs.granted_zone;
      end else begin
        iv = ifn.is_vacated_space; g = ifn.entry_grant; d = ifn.entry_deny;
        n = ifn.no_car_error; c = ifn.capacity_error; e = ifn.zone_error; gz = ifn.granted_zone;
      end
      for (int z = 0; z < ZONES; z++) begin
        chk($sformatf("k%0d_park%0d", k, z), park(k, z), m_cnt[k][z]);
        chk($sformatf("k%0d_vac%0d", k, z), vac(k, z), m_cap[k][z] - m_cnt[k][z]);
        chk($sformatf("k%0d_isvac%0d", k, z), int'(iv[z]), (m_cap[k][z] != m_cnt[k][z]) ? 1 : 0);
      end
      chk($sformatf("k%0d_grant", k), int'(g), int'(e_grant[k]));
      chk($sformatf("k%0d_deny", k), int'(d), int'(e_deny[k]));
      chk($sformatf("k%0d_nocar", k), int'(n), int'(e_nce[k]));
      chk($sformatf("k%0d_caperr", k), int'(c), int'(e_cerr[k]));
      chk($sformatf("k%0d_zoneerr", k), int'(e), int'(e_zerr[k]));
      if (e_grant[k]) chk($sformatf("k%0d_gzone", k), int'(gz), e_gz[k]);
    end
  endtask

  task automatic tick();
    apply();
    @(posedge clk);
    #1;
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    compare_all();
    car_entered = 1'b0;
    car_exited  = 1'b0;
    cap_wr      = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1;
    car_entered = 1'b0; car_exited = 1'b0; cap_wr = 1'b0;
    entry_zone = '0; exit_zone = '0; cap_zone = '0; cap_value = '0;
    tick();
    tick();
    chk("rst_vac1", vac(0, 1), 500);
    chk("rst_isvac", int'(ifs.is_vacated_space), 3);
    reset_n = 1'b1;

    // three entries to zone 1
    for (int i = 0; i < 3; i++) begin
      car_entered = 1'b1; entry_zone = 2'd1;
      tick();
      chk("tp_grant", int'(ifs.entry_grant), 1);
      chk("tp_gzone", int'(ifs.granted_zone), 1);
    end
    chk("tp_park1", park(0, 1), 3);
    chk("tp_vac1", vac(0, 1), 497);

    // capacity below occupancy is refused, then accepted after an exit
    cap_wr = 1'b1; cap_zone = 2'd1; cap_value = 10'd2;
    tick();
    chk("tp_caperr", int'(ifs.capacity_error), 1);
    chk("tp_cap_kept", vac(0, 1), 497);
    car_exited = 1'b1; exit_zone = 2'd1;
    tick();
    cap_wr = 1'b1; cap_zone = 2'd1; cap_value = 10'd2;
    tick();
    chk("tp_capok_vac", vac(0, 1), 0);
    chk("tp_capok_isvac", int'(ifs.is_vacated_space[1]), 0);

    // full reserved zone: spill versus deny
    car_entered = 1'b1; entry_zone = 2'd1;
    tick();
    chk("tp_spill_gz", int'(ifs.granted_zone), 0);
    chk("tp_spill_park0", park(0, 0), 1);
    chk("tp_nospill_deny", int'(ifn.entry_deny), 1);
    chk("tp_nospill_park1", park(1, 1), 2);

    // entry and exit on a full zone in the same cycle
    car_entered = 1'b1; entry_zone = 2'd1; car_exited = 1'b1; exit_zone = 2'd1;
    tick();
    chk("tp_swap_grant", int'(ifs.entry_grant), 1);
    chk("tp_swap_park1", park(0, 1), 2);

    // exit from empty zone 0 and an out-of-range entry
    car_exited = 1'b1; exit_zone = 2'd0;
    tick();
    chk("tp_nocar", int'(ifn.no_car_error), 1);
    chk("tp_nocar_park0", park(1, 0), 0);
    car_entered = 1'b1; entry_zone = 2'd2;
    tick();
    chk("tp_zerr", int'(ifs.zone_error), 1);
    chk("tp_zerr_nogrant", int'(ifs.entry_grant | ifs.entry_deny), 0);

    // disabled burst, then reset in the middle of an enabled burst
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      car_entered = 1'b1; entry_zone = 2'd0;
      tick();
    end
    chk("tp_dis_park0", park(1, 0), 0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reset_n = (i != 2);
      car_entered = 1'b1; entry_zone = 2'd0;
      tick();
      if (i == 2) begin
        chk("tp_rst_park0", park(0, 0), 0);
        chk("tp_rst_vac1", vac(0, 1), 500);
      end
    end
    reset_n = 1'b1;

    // random traffic with small capacities so zones fill and spill often
    for (int i = 0; i < 2000; i++) begin
      reset_n     = ($urandom_range(0, 299) != 0);
      enable      = ($urandom_range(0, 9) != 0);
      car_entered = ($urandom_range(0, 2) != 0);
      car_exited  = ($urandom_range(0, 2) == 0);
      cap_wr      = ($urandom_range(0, 7) == 0);
      entry_zone  = ZIDX_W'(($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1));
      exit_zone   = ZIDX_W'(($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1));
      cap_zone    = ZIDX_W'(($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1));
      cap_value   = CNT_W'(($urandom_range(0, 5) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 6));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
